// File: rtl/uart_tx_fifo_param_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_param_if
// Brief    : Write/status bundle between the processor side and the UART TX.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_param_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 13
);
    logic                          wr_en;
    logic [DATA_BITS-1:0]          wr_data;
    logic [DIV_WIDTH-1:0]          divisor;
    logic                          tx_en;
    logic                          TX;
    logic                          busy;
    logic                          tx_done;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;

    modport master (
        output wr_en, wr_data, divisor, tx_en,
        input  TX, busy, tx_done, fifo_full, fifo_empty, fifo_count, overflow
    );

    modport slave (
        input  wr_en, wr_data, divisor, tx_en,
        output TX, busy, tx_done, fifo_full, fifo_empty, fifo_count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_param
// Brief    : Parametrised UART transmitter fed by a circular TX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_param #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int DIV_WIDTH   = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_fifo_param_if.slave  bus
);
    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;
    localparam int c_BIT_W  = $clog2(DATA_BITS);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);
    localparam logic               c_STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_count;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_overflow;

    state_t               r_state;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_tx_done;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_baud;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [c_BIT_W-1:0]   r_bit_idx;
    logic                 r_stop_idx;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_last_stop_end;
    logic [c_PTR_W-1:0]   w_wr_nxt;
    logic [c_PTR_W-1:0]   w_rd_nxt;
    logic [c_PTR_W-1:0]   w_cnt_nxt;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

    // Full/empty are the registered flags, so a write seen while full is
    // dropped even if the transmitter pops on the same edge.
    assign w_push          = bus.wr_en && !r_full;
    assign w_last_stop_end = (r_state == ST_STOP) && (r_baud == '0) && (r_stop_idx == c_STOP_LAST);
    assign w_pop           = bus.tx_en && !r_empty && ((r_state == ST_IDLE) || w_last_stop_end);
    assign w_wr_nxt        = r_wr_ptr + c_PTR_W'(w_push);
    assign w_rd_nxt        = r_rd_ptr + c_PTR_W'(w_pop);
    assign w_cnt_nxt       = w_wr_nxt - w_rd_nxt;
    assign w_head          = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    assign w_head_par      = (PARITY_MODE == 2) ? ~^w_head : ^w_head;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_count    <= w_cnt_nxt;
            r_full     <= (w_cnt_nxt == c_PTR_W'(FIFO_DEPTH));
            r_empty    <= (w_wr_nxt == w_rd_nxt);
            r_overflow <= bus.wr_en && r_full;
        end
    end

    // tx_done is registered one cycle ahead so it is high during the final
    // cycle of the last stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
            r_div      <= '0;
            r_baud     <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (w_pop) begin
                r_state <= ST_START;
                r_busy  <= 1'b1;
                r_tx    <= 1'b0;
                r_shift <= w_head;
                r_par   <= w_head_par;
                r_div   <= bus.divisor;
                r_baud  <= bus.divisor;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    ST_START: begin
                        if (r_baud == '0) begin
                            r_state   <= ST_DATA;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= '0;
                            r_baud    <= r_div;
                        end else begin
                            r_baud <= r_baud - DIV_WIDTH'(1);
                        end
                    end
                    ST_DATA: begin
                        if (r_baud == '0) begin
                            r_baud <= r_div;
                            if (r_bit_idx == c_BIT_LAST) begin
                                if (PARITY_MODE != 0) begin
                                    r_state <= ST_PARITY;
                                    r_tx    <= r_par;
                                end else begin
                                    r_state    <= ST_STOP;
                                    r_tx       <= 1'b1;
                                    r_stop_idx <= 1'b0;
                                    r_tx_done  <= (STOP_BITS == 1) && (r_div == '0);
                                end
                            end else begin
                                r_tx      <= r_shift[0];
                                r_shift   <= r_shift >> 1;
                                r_bit_idx <= r_bit_idx + c_BIT_W'(1);
                            end
                        end else begin
                            r_baud <= r_baud - DIV_WIDTH'(1);
                        end
                    end
                    ST_PARITY: begin
                        if (r_baud == '0) begin
                            r_state    <= ST_STOP;
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
                            r_baud     <= r_div;
                            r_tx_done  <= (STOP_BITS == 1) && (r_div == '0);
                        end else begin
                            r_baud <= r_baud - DIV_WIDTH'(1);
                        end
                    end
                    ST_STOP: begin
                        if (r_baud != '0) begin
                            r_baud    <= r_baud - DIV_WIDTH'(1);
                            r_tx_done <= (r_stop_idx == c_STOP_LAST) && (r_baud == DIV_WIDTH'(1));
                        end else if (r_stop_idx != c_STOP_LAST) begin
                            r_stop_idx <= 1'b1;
                            r_baud     <= r_div;
                            r_tx_done  <= (r_div == '0);
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_tx    <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.TX         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.tx_done    = r_tx_done;
    assign bus.fifo_full  = r_full;
    assign bus.fifo_empty = r_empty;
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;
endmodule
`default_nettype wire

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised UART transmitter with an internal circular transmit FIFO. It succeeds the fixed 8N1, 8-deep TX block.
- Configurable data width, FIFO depth, parity mode and stop-bit count.
- Runtime baud divisor, a transmit-enable pause control, and an overflow indication.
- Sits between the processor I/O write path and the TX pin. The processor pushes characters; the block drains them back-to-back at the programmed baud rate.

Parameters:
DATA_BITS, 8, character width, legal 5..9, sent LSB first
FIFO_DEPTH, 8, queue entries, power of 2, >= 2
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits, 1 or 2
DIV_WIDTH, 13, width of the baud divisor

Ports:
clk  input  1  system clock
rst  input  1  reset
wr_en  input  1  push wr_data into the FIFO this cycle
wr_data  input  DATA_BITS  character to enqueue
divisor  input  DIV_WIDTH  bit period minus one, in clk cycles
tx_en  input  1  1 = frames may start; 0 = hold after the current frame
TX  output  1  serial line, idle high
busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at the end of each frame
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
fifo_empty  output  1  FIFO holds 0 entries
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently queued
overflow  output  1  one-cycle pulse when a write is dropped

Behaviour:
Interface: one clock, clk. Reset is synchronous and active-high. All state updates on the rising edge of clk only.
- Reset values: TX=1, busy=0, tx_done=0, overflow=0, fifo_count=0, fifo_empty=1, fifo_full=0, state=IDLE, pointers=0.
- Reset mid-frame: the frame is aborted and TX returns high at that edge. The FIFO is cleared.
FIFO:
- Read and write pointers are $clog2(FIFO_DEPTH)+1 bits wide. Extra MSB distinguishes full from empty.
- Full when pointer difference == FIFO_DEPTH; empty when the pointers are equal. Pointers wrap naturally.
- wr_en while full: data is discarded, pointers are unchanged, and overflow pulses for 1 cycle.
- Full is evaluated before the edge. A write while full is dropped even if a pop happens on the same edge.
- A simultaneous push (not full) and pop leaves fifo_count unchanged.
- The status outputs fifo_count, fifo_full and fifo_empty are registered and reflect the previous edge.
Framing: start bit (0), DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS stop bits (1).
- Even parity: parity bit = XOR of the data bits.
- Odd parity: parity bit = inverted XOR of the data bits.
Baud:
- The divisor is latched at the pop edge and held for the whole frame. Changes mid-frame take effect from the next frame.
- Each bit lasts divisor+1 clk cycles. Divisor 0 gives 1-cycle bits.
- The baud counter loads the latched divisor at each bit start and decrements to 0. Zero marks the bit boundary.
State machine IDLE, START, DATA, PARITY, STOP:
- IDLE: if tx_en && !fifo_empty, pop the head into the shift register, latch the divisor, then go to START. TX drives 0 from the next cycle.
- START -> DATA after one bit period.
- DATA: shift out one bit per period. After DATA_BITS bits go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY -> STOP after one bit period.
- STOP: lasts STOP_BITS periods. On the final cycle of the last stop bit, tx_done pulses.
  - If tx_en && !fifo_empty: pop and go straight to START, so there are zero idle cycles between frames.
  - Otherwise go to IDLE.
- busy = 1 in every state except IDLE.
- Lowering tx_en mid-frame completes the current frame, then holds in IDLE. Queued data is retained.
- Write-to-TX latency from an empty, idle block with tx_en=1:
  - wr_en at edge N, fifo_empty falls at N, pop at N+1.
  - TX falls after edge N+1.
- Total frame length = (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) × (divisor+1) cycles.

Test Plan:
1. Defaults with PARITY_MODE=1, divisor=3, write 0xA5 -> frame on TX is start 0, data 1,0,1,0,0,1,0,1, parity 0, stop 1. Each bit is 4 cycles, 44 cycles total. tx_done pulses once on cycle 44 and busy drops on the following cycle.
2. PARITY_MODE=2, STOP_BITS=2, divisor=0, write 0x00 -> 8 zero data bits, parity 1, two stop bits; frame is 12 cycles.
3. tx_en=0, 9 consecutive writes 0x01..0x09 -> fifo_count reaches 8 and fifo_full=1. The 9th write raises overflow for 1 cycle and is dropped. Setting tx_en=1 then transmits 0x01..0x08 in order.
4. Three writes back-to-back, divisor=1 -> three frames with no high gap between stop and next start; tx_done pulses 3 times.
5. Change divisor from 3 to 7 mid-frame -> current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.
6. Assert rst during a DATA bit, with 2 entries queued -> TX=1, busy=0, fifo_empty=1 and fifo_count=0 after that edge. No frame starts afterward without new writes.
